tmds_encoder_mc: RTL and testbench

Parametrised multi-channel TMDS encoder for the HDMI output path. It sits between the video timing/pixel pipeline and the 10:1 serialisers, and emits one 10-bit symbol per channel per pixel clock. It extends single-channel DVI encoding in four ways:
- `NUM_CH` independent channels, each with its own running-disparity counter.
- HDMI guard-band and TERC4 data-island modes.
- A 2-stage registered pipeline.
- Disparity observation outputs for verification.

---
 rtl/tmds_encoder_mc.sv | 206 ++++++++++++++++++++
 tb/tb_tmds_encoder_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_mc.sv
// -----------------------------------------------------------------------------
// tmds_encoder_mc
// Multi-channel TMDS encoder for the HDMI output path. Each channel turns one
// pixel-clock slot into one 10-bit symbol through a two-stage registered
// pipeline. It supports video (8b/10b with DC balancing), control, video
// guard band, TERC4 data island and data-island guard band periods.
//
// Ports:
//   clk   - pixel clock, all registers on the rising edge
//   rst_n - synchronous active-low reset
//   mode  - period type (0 ctrl, 1 video, 2 video guard, 3 island,
//           4 island guard, 5..7 treated as control)
//   vd    - 8 bits of video data per channel
//   cd    - 2 control bits per channel
//   aux   - 4-bit TERC4 nibble per channel
//   tmds  - 10-bit encoded symbol per channel (bit 9 is sent last)
//   disp  - signed 6-bit running disparity per channel after its symbol
//
// Build option:
//   TMDS_TERC4_EN - when defined, modes 3 and 4 emit TERC4 symbols from aux.
//                   When undefined, modes 3 and 4 encode as control and aux
//                   is ignored.
// -----------------------------------------------------------------------------
module tmds_encoder_mc #(
  parameter int NUM_CH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            mode,
  input  logic [8*NUM_CH-1:0]   vd,
  input  logic [2*NUM_CH-1:0]   cd,
  input  logic [4*NUM_CH-1:0]   aux,
  output logic [10*NUM_CH-1:0]  tmds,
  output logic [6*NUM_CH-1:0]   disp
);

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_DGUARD = 3'd4
  } mode_e;

  function automatic logic [9:0] ctrlSym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4Sym(input logic [3:0] a);
    logic [9:0] s;
    case (a)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction
`else
  // aux has no consumer in this build; the name keeps lint quiet about it.
  logic unusedAux;
  assign unusedAux = ^aux;
`endif

  mode_e stgMode_d, stgMode_q;

  // Normalise the raw mode into the set of periods this build supports, so
  // stage 2 never has to treat reserved or disabled codes specially.
  always_comb begin
    stgMode_d = MODE_CTRL;
    case (mode)
      3'd1:    stgMode_d = MODE_VIDEO;
      3'd2:    stgMode_d = MODE_VGUARD;
`ifdef TMDS_TERC4_EN
      3'd3:    stgMode_d = MODE_ISLAND;
      3'd4:    stgMode_d = MODE_DGUARD;
`endif
      default: stgMode_d = MODE_CTRL;
    endcase
  end

  // Stage-1 mode register, shared by all channels.
  always_ff @(posedge clk) begin
    if (!rst_n) stgMode_q <= MODE_CTRL;
    else        stgMode_q <= stgMode_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic [7:0]        vdCh;
    logic [3:0]        ones;
    logic [3:0]        qOnes;
    logic              useXnor;
    logic signed [5:0] nWide;
    logic [8:0]        qm_d, qm_q;
    logic signed [4:0] n_d, n_q;
    logic [1:0]        cd_q;
`ifdef TMDS_TERC4_EN
    logic [3:0]        aux_q;
`endif
    logic signed [5:0] nExt;
    logic [9:0]        tmds_d, tmds_q;
    logic signed [5:0] cnt_d, cnt_q;

    assign vdCh = vd[8*g +: 8];
    assign nExt = {n_q[4], n_q};

    // Transition-minimising stage: pick XOR or XNOR chaining, then record the
    // ones-minus-zeros balance of the chained byte for the DC balancer.
    always_comb begin
      ones = '0;
      for (int k = 0; k < 8; k++) ones = ones + {3'b000, vdCh[k]};
      useXnor = (ones > 4'd4) || ((ones == 4'd4) && !vdCh[0]);
      qm_d = '0;
      qm_d[0] = vdCh[0];
      for (int k = 1; k < 8; k++) qm_d[k] = qm_d[k-1] ^ vdCh[k] ^ useXnor;
      qm_d[8] = ~useXnor;
      qOnes = '0;
      for (int k = 0; k < 8; k++) qOnes = qOnes + {3'b000, qm_d[k]};
      nWide = $signed({1'b0, qOnes, 1'b0}) - 6'sd8;
      n_d = nWide[4:0];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        qm_q <= '0;
        n_q  <= '0;
        cd_q <= '0;
      end else begin
        qm_q <= qm_d;
        n_q  <= n_d;
        cd_q <= cd[2*g +: 2];
      end
    end

`ifdef TMDS_TERC4_EN
    always_ff @(posedge clk) begin
      if (!rst_n) aux_q <= '0;
      else        aux_q <= aux[4*g +: 4];
    end
`endif

    // Symbol selection. Video runs the DC balancer against the running
    // disparity; every other period emits a fixed symbol and clears it, so the
    // next video burst always starts balanced.
    always_comb begin
      tmds_d = ctrlSym(cd_q);
      cnt_d  = 6'sd0;
      case (stgMode_q)
        MODE_VIDEO: begin
          if ((cnt_q == 6'sd0) || (n_q == 5'sd0)) begin
            tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d  = qm_q[8] ? (cnt_q + nExt) : (cnt_q - nExt);
          end else if (((cnt_q > 6'sd0) && (n_q > 5'sd0)) ||
                       ((cnt_q < 6'sd0) && (n_q < 5'sd0))) begin
            tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d  = cnt_q + (qm_q[8] ? 6'sd2 : 6'sd0) - nExt;
          end else begin
            tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d  = cnt_q + nExt - (qm_q[8] ? 6'sd0 : 6'sd2);
          end
        end
        MODE_VGUARD: tmds_d = ((g % 2) == 0) ? 10'b1011001100 : 10'b0100110011;
`ifdef TMDS_TERC4_EN
        MODE_ISLAND: tmds_d = terc4Sym(aux_q);
        // Only channel 0 carries sync bits during the island guard band.
        MODE_DGUARD: tmds_d = (g == 0) ? terc4Sym({2'b11, cd_q}) : 10'b0100110011;
`endif
        default: tmds_d = ctrlSym(cd_q);
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        tmds_q <= 10'b1101010100;
        cnt_q  <= 6'sd0;
      end else begin
        tmds_q <= tmds_d;
        cnt_q  <= cnt_d;
      end
    end

    assign tmds[10*g +: 10] = tmds_q;
    assign disp[6*g +: 6]   = cnt_q;
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// -----------------------------------------------------------------------------
// tb_tmds_encoder_mc
// Self-checking bench for tmds_encoder_mc with three channels. A directed
// vector table covers reset, control, video balancing, guard bands and TERC4;
// a hand-written sequence covers reset in the middle of video; a randomised
// phase is compared against a behavioural model of the encoding rules.
// Honours TMDS_TERC4_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_tmds_encoder_mc;

  localparam int NUM_CH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mode;
  logic [23:0] vd;
  logic [5:0]  cd;
  logic [11:0] aux;
  logic [29:0] tmds;
  logic [17:0] disp;

  always #5 clk = ~clk;

  tmds_encoder_mc #(.NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .vd    (vd),
    .cd    (cd),
    .aux   (aux),
    .tmds  (tmds),
    .disp  (disp)
  );

  localparam logic [9:0] CTRL_SYM [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  localparam logic [9:0] TERC4_SYM [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  typedef struct {
    logic        rstn;
    logic [2:0]  mode;
    logic [23:0] vd;
    logic [5:0]  cd;
    logic [11:0] aux;
    logic [29:0] expTmds;
    logic [17:0] expDisp;
  } vec_t;

  vec_t vecs[14];

  int checks = 0;
  int passes = 0;

  // Behavioural model state: the input waiting in the pipeline plus the
  // running disparity of each channel.
  int          cntM [NUM_CH];
  logic [2:0]  pMode;
  logic [23:0] pVd;
  logic [5:0]  pCd;
  logic [11:0] pAux;
  logic [29:0] modelTmds;
  logic [17:0] modelDisp;

  // Encode one symbol straight from the encoding rules using integer math.
  function automatic logic [9:0] encodeRef(input int ch, input logic [2:0] m,
                                           input logic [7:0] d, input logic [1:0] c,
                                           input logic [3:0] a, input logic [1:0] c0);
    logic [9:0] sym;
    logic [7:0] q;
    logic       inv;
    logic       q8;
    int         n;
    sym = CTRL_SYM[c];
    if (m == 3'd1) begin
      inv = ($countones(d) > 4) || (($countones(d) == 4) && (d[0] == 1'b0));
      q[0] = d[0];
      for (int k = 1; k < 8; k++) q[k] = q[k-1] ^ d[k] ^ inv;
      q8 = ~inv;
      n = 2 * $countones(q) - 8;
      if ((cntM[ch] == 0) || (n == 0)) begin
        sym = {~q8, q8, q8 ? q : ~q};
        cntM[ch] = cntM[ch] + (q8 ? n : -n);
      end else if ((cntM[ch] > 0) == (n > 0)) begin
        sym = {1'b1, q8, ~q};
        cntM[ch] = cntM[ch] + (q8 ? 2 : 0) - n;
      end else begin
        sym = {1'b0, q8, q};
        cntM[ch] = cntM[ch] + n - (q8 ? 0 : 2);
      end
    end else begin
      cntM[ch] = 0;
      case (m)
        3'd2: sym = ((ch % 2) == 0) ? 10'b1011001100 : 10'b0100110011;
`ifdef TMDS_TERC4_EN
        3'd3: sym = TERC4_SYM[a];
        3'd4: sym = (ch == 0) ? TERC4_SYM[{2'b11, c0}] : 10'b0100110011;
`endif
        default: sym = CTRL_SYM[c];
      endcase
    end
    return sym;
  endfunction

  // Advance the model by one clock edge.
  task automatic stepModel(input logic r, input logic [2:0] m, input logic [23:0] v,
                           input logic [5:0] c, input logic [11:0] a);
    if (!r) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cntM[ch] = 0;
        modelTmds[10*ch +: 10] = CTRL_SYM[0];
      end
      pMode = 3'd0; pVd = '0; pCd = '0; pAux = '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++)
        modelTmds[10*ch +: 10] = encodeRef(ch, pMode, pVd[8*ch +: 8], pCd[2*ch +: 2],
                                           pAux[4*ch +: 4], pCd[1:0]);
      pMode = m; pVd = v; pCd = c; pAux = a;
    end
    for (int ch = 0; ch < NUM_CH; ch++) modelDisp[6*ch +: 6] = 6'(cntM[ch]);
  endtask

  // Drive one cycle of inputs, clock them in, and leave time for outputs to settle.
  task automatic applyStimulus(input logic r, input logic [2:0] m, input logic [23:0] v,
                               input logic [5:0] c, input logic [11:0] a);
    @(negedge clk);
    rst_n = r; mode = m; vd = v; cd = c; aux = a;
    @(posedge clk);
    stepModel(r, m, v, c, a);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int idx,
                             input logic [29:0] wantT, input logic [17:0] wantD);
    checks++;
    if (tmds === wantT) passes++;
    else $display("[TB] FAIL %s tmds #%0d: got %b want %b", tag, idx, tmds, wantT);
    checks++;
    if (disp === wantD) passes++;
    else $display("[TB] FAIL %s disp #%0d: got %h want %h", tag, idx, disp, wantD);
  endtask

  task automatic setVec(input int i, input logic r, input logic [2:0] m, input logic [23:0] v,
                        input logic [5:0] c, input logic [11:0] a,
                        input logic [29:0] t, input logic [17:0] d);
    vecs[i].rstn = r; vecs[i].mode = m; vecs[i].vd = v; vecs[i].cd = c;
    vecs[i].aux = a; vecs[i].expTmds = t; vecs[i].expDisp = d;
  endtask

  localparam logic [29:0] ALL_CTRL0 = {3{10'b1101010100}};
  localparam logic [29:0] ALL_V00A  = {3{10'b0100000000}};
  localparam logic [29:0] ALL_V00B  = {3{10'b1111111111}};
  localparam logic [17:0] D_ZERO    = '0;
  localparam logic [17:0] D_M8      = {3{6'b111000}};
  localparam logic [17:0] D_P2      = {3{6'b000010}};
  localparam logic [17:0] D_M6      = {3{6'b111010}};

  initial begin
    logic [29:0] islandExp;
    logic [29:0] dguardExp;
    logic [2:0]  rm;
`ifdef TMDS_TERC4_EN
    islandExp = {10'b1011000011, 10'b1010011100, 10'b0100011110};
    dguardExp = {10'b0100110011, 10'b0100110011, 10'b0101100011};
`else
    islandExp = ALL_CTRL0;
    dguardExp = {10'b1101010100, 10'b1101010100, 10'b0101010100};
`endif
    // Each row's expectation is the output after that row's clock edge,
    // i.e. the symbol for the row before it.
    setVec(0,  1'b0, 3'($urandom), 24'($urandom), 6'($urandom), 12'($urandom), ALL_CTRL0, D_ZERO);
    setVec(1,  1'b0, 3'($urandom), 24'($urandom), 6'($urandom), 12'($urandom), ALL_CTRL0, D_ZERO);
    setVec(2,  1'b0, 3'($urandom), 24'($urandom), 6'($urandom), 12'($urandom), ALL_CTRL0, D_ZERO);
    setVec(3,  1'b1, 3'd0, 24'h0, 6'b11_10_01, 12'h0, ALL_CTRL0, D_ZERO);
    setVec(4,  1'b1, 3'd1, 24'h0, 6'b00_00_00, 12'h0,
           {10'b1010101011, 10'b0101010100, 10'b0010101011}, D_ZERO);
    setVec(5,  1'b1, 3'd1, 24'h0, 6'b00_00_00, 12'h0, ALL_V00A, D_M8);
    setVec(6,  1'b1, 3'd1, 24'h0, 6'b00_00_00, 12'h0, ALL_V00B, D_P2);
    setVec(7,  1'b1, 3'd2, 24'h0, 6'b00_00_00, 12'h0, ALL_V00A, D_M6);
    setVec(8,  1'b1, 3'd1, 24'h0, 6'b00_00_00, 12'h0,
           {10'b1011001100, 10'b0100110011, 10'b1011001100}, D_ZERO);
    setVec(9,  1'b1, 3'd3, 24'h0, 6'b00_00_00, 12'hF05, ALL_V00A, D_M8);
    setVec(10, 1'b1, 3'd0, 24'h0, 6'b00_00_00, 12'h0, islandExp, D_ZERO);
    setVec(11, 1'b1, 3'd4, 24'h0, 6'b00_00_10, 12'h0, ALL_CTRL0, D_ZERO);
    setVec(12, 1'b1, 3'd7, 24'h0, 6'b00_11_01, 12'h0, dguardExp, D_ZERO);
    setVec(13, 1'b1, 3'd0, 24'h0, 6'b00_00_00, 12'h0,
           {10'b1101010100, 10'b1010101011, 10'b0010101011}, D_ZERO);

    rst_n = 1'b0; mode = '0; vd = '0; cd = '0; aux = '0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].mode, vecs[i].vd, vecs[i].cd, vecs[i].aux);
      checkOutput("table", i, vecs[i].expTmds, vecs[i].expDisp);
    end

    // Reset pulse in the middle of a video burst.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd1, 24'($urandom), 6'($urandom), 12'($urandom));
      checkOutput("midvideo", i, modelTmds, modelDisp);
    end
    applyStimulus(1'b0, 3'd1, 24'($urandom), 6'($urandom), 12'($urandom));
    checkOutput("midreset", 0, ALL_CTRL0, D_ZERO);
    applyStimulus(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
    checkOutput("midreset", 1, ALL_CTRL0, D_ZERO);
    applyStimulus(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
    checkOutput("midreset", 2, ALL_V00A, D_M8);
    applyStimulus(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
    checkOutput("midreset", 3, ALL_V00B, D_P2);

    // Randomised traffic, mostly video, with one reset pulse in the middle.
    for (int i = 0; i < 400; i++) begin
      rm = ($urandom_range(0, 9) < 7) ? 3'd1 : 3'($urandom_range(0, 7));
      applyStimulus((i == 200) ? 1'b0 : 1'b1, rm, 24'($urandom), 6'($urandom), 12'($urandom));
      checkOutput("random", i, modelTmds, modelDisp);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
